id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, register-file data / immediate width.
REQ-002 Parameter PC_W, default 9, program-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_pc, id_rd1, id_rd2, id_imm  input  PC_W / DATA_W / DATA_W / DATA_W  decode PC, operands, immediate.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-008 id_funct3 / id_funct7  input  3 / 7  instruction bits 14:12 / 31:25.
REQ-009 id_ctrl  input  ctrl_t  ALUOp[1:0], ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch.
REQ-010 ext_stall  input  1  downstream (memory) stall; hold stage.
REQ-011 flush  input  1  branch taken in EX; kill the incoming instruction.
REQ-012 ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_ctrl  output  matching widths  registered EX-stage copies; ex_ctrl.ALUOp, ex_funct3, ex_funct7 feed the ALU controller.
REQ-013 hazard_o  output  1  combinational load-use hazard; IF and IF/ID hold while high.

Function
REQ-014 Latency exactly one cycle: fields captured at edge N appear on ex_* after edge N.
REQ-015 Load-use hazard SHALL be hazard_o = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-016 Per-edge priority: reset > flush > ext_stall > hazard_o > normal load.
REQ-017 Flush: ex_valid <= 0, ex_ctrl <= all zero (ALUOp = 2'b00), data/index/funct fields <= 0.
REQ-018 ext_stall (no flush): every ex_* register holds its value.
REQ-019 hazard_o without ext_stall/flush: bubble inserted exactly as REQ-017; id_* is not consumed and is re-presented next cycle.
REQ-020 Normal: all ex_* <= id_*; ex_valid <= id_valid; if id_valid = 0, ex_ctrl <= zero.
REQ-021 ex_ctrl SHALL never carry RegWrite, MemRead, MemWrite or Branch = 1 while ex_valid = 0.
REQ-022 hazard_o SHALL remain asserted throughout ext_stall while its condition holds; it clears the cycle after the bubble is in EX.
REQ-023 Register index x0 SHALL never raise a hazard.

Reset
REQ-024 With rst_n = 0 at an edge, all ex_* outputs and counters SHALL be zero; reset overrides flush and ext_stall.
REQ-025 Reset mid-stall or mid-hazard SHALL leave no pending bubble; first post-reset edge is a normal load.

Configuration
REQ-026 Macro ID_EX_PERF_CNT_EN defined: outputs bubble_cnt[15:0] and flush_cnt[15:0], saturating at 16'hFFFF, incremented on each edge inserting a hazard bubble / executing a flush (not during ext_stall).
REQ-027 Macro undefined: the counter ports and logic SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package pipe_pkg SHALL hold ctrl_t (packed struct), the ALUOp constants ALUOP_LDST = 2'b00, ALUOP_BRANCH = 2'b01, ALUOP_RTYPE = 2'b10, and CTRL_NOP (all-zero).
REQ-029 Sub-module hazard_detect SHALL implement REQ-015/REQ-023 combinationally; id_ex_stage instantiates it once.

Verification
REQ-030 Normal: id_valid=1, ADD (funct3=000, funct7=0000000, ALUOp=10, rd1=5, rd2=7) -> next cycle ex_* equal inputs, ex_valid=1.
REQ-031 Load-use: EX holds lw x5 (MemRead=1, rd=5); ID add x6,x5,x1 -> hazard_o=1 same cycle; next cycle ex_valid=0, ex_ctrl=0, hazard_o=0; add enters EX one cycle later.
REQ-032 x0: EX lw x0; ID uses rs1=0 -> hazard_o=0, no bubble.
REQ-033 Flush+stall: flush=1, ext_stall=1, valid sub in ID -> next cycle ex_valid=0, ex_ctrl=0.
REQ-034 Stall+hazard: ext_stall=1 for 3 cycles with load-use condition -> ex_* frozen, hazard_o=1 all 3 cycles; bubble on first unstalled edge; bubble_cnt +1 only (PERF build).
REQ-035 Reset: rst_n=0 during stall with ex_valid=1 -> next edge all ex_* = 0, counters = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline types for the ID/EX stage:
//   ctrl_t       - packed decode control bundle (ALUOp, ALUSrc, MemtoReg,
//                  RegWrite, MemRead, MemWrite, Branch)
//   ALUOP_*      - ALUOp encodings consumed by the ALU controller
//   CTRL_NOP     - all-zero control word used for bubbles and flushes
//   REG_IDX_W    - register index width
//   sat_inc16()  - saturating 16-bit increment for the optional perf counters
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. Raises hazard_o when the
// instruction in EX is a valid load whose destination (other than x0) is a
// source of the valid instruction sitting in ID.
// Ports:
//   id_valid, id_rs1, id_rs2      - instruction in decode
//   ex_valid, ex_mem_read, ex_rd  - instruction currently in EX
//   hazard_o                      - stall IF and IF/ID, bubble into EX
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 hazard_o
);

    logic rd_nonzero;
    logic rd_match;

    // x0 is hardwired to zero, so a load into it never produces a dependency.
    assign rd_nonzero = (ex_rd != '0);
    assign rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    assign hazard_o   = id_valid && ex_valid && ex_mem_read && rd_nonzero && rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection.
// Per-edge priority: reset > flush > ext_stall > load-use bubble > load.
// Ports:
//   clk, rst_n (synchronous, active low)
//   id_*       - decode-stage instruction fields and control word
//   ext_stall  - downstream stall, every EX register holds
//   flush      - kill the incoming instruction (EX becomes a bubble)
//   ex_*       - registered EX-stage copies
//   hazard_o   - combinational load-use hazard (IF and IF/ID hold)
// Optional build macro ID_EX_PERF_CNT_EN adds saturating bubble_cnt and
// flush_cnt outputs; without it the counters do not exist.
// -----------------------------------------------------------------------------
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [PC_W-1:0]      id_pc,
    input  logic [DATA_W-1:0]    id_rd1,
    input  logic [DATA_W-1:0]    id_rd2,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [2:0]           id_funct3,
    input  logic [6:0]           id_funct7,
    input  ctrl_t                id_ctrl,
    input  logic                 ext_stall,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [PC_W-1:0]      ex_pc,
    output logic [DATA_W-1:0]    ex_rd1,
    output logic [DATA_W-1:0]    ex_rd2,
    output logic [DATA_W-1:0]    ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [2:0]           ex_funct3,
    output logic [6:0]           ex_funct7,
    output ctrl_t                ex_ctrl,
`ifdef ID_EX_PERF_CNT_EN
    output logic [15:0]          bubble_cnt,
    output logic [15:0]          flush_cnt,
`endif
    output logic                 hazard_o
);

    logic                 valid_q,  valid_d;
    logic [PC_W-1:0]      pc_q,     pc_d;
    logic [DATA_W-1:0]    rd1_q,    rd1_d;
    logic [DATA_W-1:0]    rd2_q,    rd2_d;
    logic [DATA_W-1:0]    imm_q,    imm_d;
    logic [REG_IDX_W-1:0] rs1_q,    rs1_d;
    logic [REG_IDX_W-1:0] rs2_q,    rs2_d;
    logic [REG_IDX_W-1:0] rd_q,     rd_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [6:0]           funct7_q, funct7_d;
    ctrl_t                ctrl_q,   ctrl_d;
    logic                 hazard;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .hazard_o    (hazard)
    );

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        ctrl_d   = ctrl_q;

        if (flush || (!ext_stall && hazard)) begin
            // Flush and load-use bubble both leave a fully zeroed slot in EX.
            valid_d  = 1'b0;
            pc_d     = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            funct3_d = '0;
            funct7_d = '0;
            ctrl_d   = CTRL_NOP;
        end else if (!ext_stall) begin
            valid_d  = id_valid;
            pc_d     = id_pc;
            rd1_d    = id_rd1;
            rd2_d    = id_rd2;
            imm_d    = id_imm;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            funct3_d = id_funct3;
            funct7_d = id_funct7;
            // An invalid slot must never carry side-effecting control bits.
            ctrl_d   = id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            ctrl_q   <= CTRL_NOP;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            ctrl_q   <= ctrl_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = sat_inc16(flush_cnt_q);
        end else if (!ext_stall && hazard) begin
            bubble_cnt_d = sat_inc16(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

    assign ex_valid  = valid_q;
    assign ex_pc     = pc_q;
    assign ex_rd1    = rd1_q;
    assign ex_rd2    = rd2_q;
    assign ex_imm    = imm_q;
    assign ex_rs1    = rs1_q;
    assign ex_rs2    = rs2_q;
    assign ex_rd     = rd_q;
    assign ex_funct3 = funct3_q;
    assign ex_funct7 = funct7_q;
    assign ex_ctrl   = ctrl_q;
    assign hazard_o  = hazard;

endmodule
